// File: rtl/ppi_pkg.sv
// Shared definitions for the 8255 bus sequencer slice.
// - ppi_state_e : sequencer FSM encoding
// - PPI_A_*     : 8255 A1:A0 register addresses
// - CW_*        : control-word field positions (mode-set flag, BSR bit select)
// - in_access() : true in the states that hold CS low
package ppi_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SETUP   = 3'd2,
    ST_STROBE  = 3'd3,
    ST_HOLD    = 3'd4,
    ST_RECOVER = 3'd5
  } ppi_state_e;

  localparam logic [1:0] PPI_A_PA = 2'b00;
  localparam logic [1:0] PPI_A_PB = 2'b01;
  localparam logic [1:0] PPI_A_PC = 2'b10;
  localparam logic [1:0] PPI_A_CW = 2'b11;

  // Control word: bit 7 set = mode-set word, clear = bit set/reset word
  // whose port C bit index sits in [3:1].
  localparam int CW_MODE_SET_BIT = 7;
  localparam int CW_BSR_SEL_MSB  = 3;
  localparam int CW_BSR_SEL_LSB  = 1;

  function automatic logic in_access(input ppi_state_e s);
    return (s == ST_SETUP) || (s == ST_STROBE) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/ppi_bus_sequencer_if.sv
// Request/response channel between a bus master and ppi_bus_sequencer.
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both high; req_write/req_addr/req_wdata must be stable while
// req_valid is high and are don't-care afterwards (the sequencer latches them).
// rsp_valid is a one-cycle pulse with no back-pressure; rsp_rdata carries read
// data with it and otherwise holds its last value.
// - master modport : the requester
// - slave modport  : the sequencer
interface ppi_bus_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ppi_cyc_timer.sv
// Loadable 8-bit down-counter with a zero flag; paces every phase of the
// sequencer. Load wins over decrement; decrement stops at zero.
// - clk      : clock
// - load     : load load_val this edge
// - load_val : value to load
// - dec      : decrement this edge
// - cnt      : current count
// - zero     : cnt == 0
module ppi_cyc_timer (
  input  logic       clk,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [7:0] cnt,
  output logic       zero
);

  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 8'd0)) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign zero = (cnt == 8'd0);

endmodule

// File: rtl/ppi_bus_sequencer.sv
// Clocked bus master driving the CPU-side pins of an 8255 core with
// programmable setup/strobe/hold/recovery timing, plus the post-reset chip
// RESET pulse.
// - clk, RESET        : clock, synchronous active-high reset
// - bus (slave)       : request/response channel
// - ppi_reset         : 8255 RESET
// - ppi_cs_n/rd_n/wr_n: 8255 chip select and strobes (active low)
// - ppi_a             : 8255 A1:A0
// - ppi_d_out/d_oe    : data toward PORTD and its pad drive enable
// - ppi_d_in          : data sampled from PORTD
// - dbg_state/dbg_cnt : FSM state and phase counter
module ppi_bus_sequencer
  import ppi_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned STROBE_CYC  = 3,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned RECOVER_CYC = 2,
  parameter int unsigned INIT_CYC    = 4
) (
  input  logic                 clk,
  input  logic                 RESET,
  ppi_bus_sequencer_if.slave   bus,
  output logic                 ppi_reset,
  output logic                 ppi_cs_n,
  output logic                 ppi_rd_n,
  output logic                 ppi_wr_n,
  output logic [1:0]           ppi_a,
  output logic [7:0]           ppi_d_out,
  output logic                 ppi_d_oe,
  input  logic [7:0]           ppi_d_in,
  output ppi_state_e           dbg_state,
  output logic [7:0]           dbg_cnt
);

  localparam logic [7:0] INIT_LD    = 8'(INIT_CYC - 1);
  localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD  = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD    = 8'(HOLD_CYC - 1);
  localparam logic [7:0] RECOVER_LD = 8'(RECOVER_CYC - 1);
  // Where an access ends: the first cycle after the strobe/hold phase is
  // already a recovery (or idle) cycle, carrying rsp_valid with CS high.
  localparam ppi_state_e END_STATE = (RECOVER_CYC != 0) ? ST_RECOVER : ST_IDLE;

  ppi_state_e state_q, state_d;
  logic       wr_q;
  logic       tmr_load, tmr_dec, tmr_zero;
  logic [7:0] tmr_val, cnt;

  logic       accept, next_wr, busy_d, capture;
  logic       ppi_reset_d, cs_n_d, rd_n_d, wr_n_d, d_oe_d, rsp_valid_d;
  logic       rsp_valid_q;
  logic [7:0] rsp_rdata_q;

  ppi_cyc_timer u_timer (
    .clk      (clk),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .cnt      (cnt),
    .zero     (tmr_zero)
  );

  // State register plus the registered pin/response outputs.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    ppi_reset   <= ppi_reset_d;
    ppi_cs_n    <= cs_n_d;
    ppi_rd_n    <= rd_n_d;
    ppi_wr_n    <= wr_n_d;
    ppi_d_oe    <= d_oe_d;
    rsp_valid_q <= rsp_valid_d;
    if (RESET) begin
      wr_q        <= 1'b0;
      ppi_a       <= 2'b00;
      ppi_d_out   <= 8'h00;
      rsp_rdata_q <= 8'h00;
    end else begin
      // A/D only move on acceptance, so they are frozen for the whole access.
      if (accept) begin
        wr_q      <= bus.req_write;
        ppi_a     <= bus.req_addr;
        ppi_d_out <= bus.req_wdata;
      end
      if (capture) begin
        rsp_rdata_q <= ppi_d_in;
      end
    end
  end

  // Next state and phase counter control.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = 8'h00;
    tmr_dec  = 1'b0;
    if (RESET) begin
      state_d  = ST_INIT;
      tmr_load = 1'b1;
      tmr_val  = INIT_LD;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (tmr_zero) state_d = ST_IDLE;
          else          tmr_dec = 1'b1;
        end
        ST_IDLE: begin
          if (bus.req_valid) begin
            state_d  = ST_SETUP;
            tmr_load = 1'b1;
            tmr_val  = SETUP_LD;
          end
        end
        ST_SETUP: begin
          if (tmr_zero) begin
            state_d  = ST_STROBE;
            tmr_load = 1'b1;
            tmr_val  = STROBE_LD;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        ST_STROBE: begin
          if (tmr_zero) begin
            tmr_load = 1'b1;
            if (HOLD_CYC != 0) begin
              state_d = ST_HOLD;
              tmr_val = HOLD_LD;
            end else begin
              state_d = END_STATE;
              tmr_val = RECOVER_LD;
            end
          end else begin
            tmr_dec = 1'b1;
          end
        end
        ST_HOLD: begin
          if (tmr_zero) begin
            state_d  = END_STATE;
            tmr_load = 1'b1;
            tmr_val  = RECOVER_LD;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        ST_RECOVER: begin
          if (tmr_zero) state_d = ST_IDLE;
          else          tmr_dec = 1'b1;
        end
        default: begin
          state_d  = ST_INIT;
          tmr_load = 1'b1;
          tmr_val  = INIT_LD;
        end
      endcase
    end
  end

  // Pin values are decoded from the next state so they register in the same
  // edge as the state change; strobes therefore only ever fall inside a
  // CS-low window and can never overlap.
  always_comb begin
    accept      = (state_q == ST_IDLE) && bus.req_valid && !RESET;
    next_wr     = accept ? bus.req_write : wr_q;
    busy_d      = in_access(state_d);
    ppi_reset_d = (state_d == ST_INIT);
    cs_n_d      = !busy_d;
    rd_n_d      = !((state_d == ST_STROBE) && !next_wr);
    wr_n_d      = !((state_d == ST_STROBE) && next_wr);
    d_oe_d      = busy_d && next_wr;
    rsp_valid_d = ((state_q == ST_STROBE) || (state_q == ST_HOLD)) &&
                  !busy_d && !RESET;
    capture     = (state_q == ST_STROBE) && tmr_zero && !wr_q && !RESET;
  end

  assign bus.req_ready = (state_q == ST_IDLE) && !RESET;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign dbg_state     = state_q;
  assign dbg_cnt       = cnt;

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
module tb_ppi_bus_sequencer;
  import ppi_pkg::*;

  localparam int SETUP   = 2;
  localparam int STROBE  = 3;
  localparam int HOLD    = 1;
  localparam int RECOVER = 2;
  localparam int INIT    = 4;
  localparam int LAT     = SETUP + STROBE + HOLD + 1;
  localparam int PERIOD  = SETUP + STROBE + HOLD + RECOVER + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic RESET = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ppi_bus_sequencer_if bus ();

  logic       ppi_reset, cs_n, rd_n, wr_n, d_oe;
  logic [1:0] ppi_a;
  logic [7:0] d_out, d_in, dbg_cnt;
  ppi_state_e dbg_state;

  // 8255 stand-in: register contents appear on PORTD only while RD_n is low.
  logic [7:0] dev_mem [4];
  assign d_in = rd_n ? 8'h3C : dev_mem[ppi_a];

  ppi_bus_sequencer #(
    .SETUP_CYC(SETUP), .STROBE_CYC(STROBE), .HOLD_CYC(HOLD),
    .RECOVER_CYC(RECOVER), .INIT_CYC(INIT)
  ) dut (
    .clk       (clk),
    .RESET     (RESET),
    .bus       (bus),
    .ppi_reset (ppi_reset),
    .ppi_cs_n  (cs_n),
    .ppi_rd_n  (rd_n),
    .ppi_wr_n  (wr_n),
    .ppi_a     (ppi_a),
    .ppi_d_out (d_out),
    .ppi_d_oe  (d_oe),
    .ppi_d_in  (d_in),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // exp entry: [18] write, [17:16] addr, [15:8] wdata, [7:0] expected rsp_rdata
  logic [18:0] exp_q[$];
  int          acc_q[$];
  logic [10:0] req_q[$];            // {write, addr, wdata}
  logic [7:0]  last_rd = 8'h00;     // model of rsp_rdata
  int          last_rsp_cyc = 0;

  // ---------------- driver ----------------
  task automatic run_reqs(input bit b2b_chk);
    logic [10:0] r;
    logic [7:0]  rd;
    int          bound;
    int          last_acc;
    last_acc = -1;
    @(posedge clk); #1;
    while (req_q.size() != 0) begin
      r = req_q.pop_front();
      bus.req_valid = 1'b1;
      bus.req_write = r[10];
      bus.req_addr  = r[9:8];
      bus.req_wdata = r[7:0];
      bound = 0;
      forever begin
        @(negedge clk);
        if (bus.req_ready || bound >= 50) break;
        bound++;
      end
      if (!bus.req_ready) begin
        check("ready_timeout", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b0;
        req_q.delete();
        return;
      end
      // handshake completes on the coming rising edge
      if (r[10]) begin
        rd = last_rd;
      end else begin
        rd = dev_mem[r[9:8]];
        last_rd = rd;
      end
      exp_q.push_back({r[10], r[9:8], r[7:0], rd});
      acc_q.push_back(cyc);
      if (b2b_chk && last_acc >= 0) begin
        check("b2b_period", cyc - last_acc, PERIOD);
        check("b2b_accept_after_rsp", cyc - last_rsp_cyc, RECOVER);
      end
      last_acc = cyc;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int bound;
    bound = 0;
    while (exp_q.size() != 0 && bound < 300) begin
      @(negedge clk);
      bound++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic release_reset(input string tag);
    int n;
    @(posedge clk); #1;
    RESET = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (!ppi_reset || n >= 20) break;
      n++;
    end
    check({tag, "_init_cycles"}, n, INIT);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- monitor ----------------
  logic       prev_strobe = 1'b0;
  logic       prev_cs_n   = 1'b1;
  logic [1:0] prev_a      = 2'b00;
  logic [7:0] prev_d      = 8'h00;
  logic       aborted     = 1'b0;
  logic       shape_bad   = 1'b0;
  logic       gap_valid   = 1'b0;
  logic       b2b_mode    = 1'b0;
  int         n_setup = 0, n_strobe = 0, n_hold = 0, gap = 0;

  always @(negedge clk) begin
    logic        strobe;
    logic [18:0] head;
    logic [18:0] e;
    int          a;
    strobe = !rd_n || !wr_n;
    if (RESET) aborted = 1'b1;

    check("rd_wr_overlap", 32'(!rd_n && !wr_n), 32'd0);
    if (strobe) check("strobe_without_cs", 32'(cs_n), 32'd0);
    if (strobe && prev_strobe) begin
      check("a_stable", 32'(ppi_a), 32'(prev_a));
      check("d_stable", 32'(d_out), 32'(prev_d));
    end

    if (!cs_n) begin
      if (prev_cs_n) begin
        if (b2b_mode && gap_valid) check("cs_gap_after_rsp", gap, RECOVER);
        gap_valid = 1'b0;
        n_setup = 0; n_strobe = 0; n_hold = 0;
        shape_bad = 1'b0;
        aborted = RESET;
      end
      if (strobe)             n_strobe++;
      else if (n_strobe == 0) n_setup++;
      else                    n_hold++;
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        if (ppi_a !== head[17:16]) shape_bad = 1'b1;
        if (d_oe !== head[18]) shape_bad = 1'b1;
        if (head[18] && d_out !== head[15:8]) shape_bad = 1'b1;
        if (head[18] ? !rd_n : !wr_n) shape_bad = 1'b1;
      end else begin
        shape_bad = 1'b1;
      end
    end else if (!prev_cs_n && !aborted) begin
      check("setup_cycles", n_setup, SETUP);
      check("strobe_cycles", n_strobe, STROBE);
      check("hold_cycles", n_hold, HOLD);
      check("pins_during_access", 32'(shape_bad), 32'd0);
      check("oe_at_end", 32'(d_oe), 32'd0);
      gap = 0;
      gap_valid = 1'b1;
    end else if (cs_n && !bus.rsp_valid) begin
      gap++;
    end

    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e[7:0]));
        check("rsp_latency", cyc - a, LAT);
        check("rsp_cs_high", 32'(cs_n), 32'd1);
      end
      last_rsp_cyc = cyc;
    end

    prev_strobe = strobe;
    prev_cs_n   = cs_n;
    prev_a      = ppi_a;
    prev_d      = d_out;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [7:0] cw;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 2'b00;
    bus.req_wdata = 8'h00;
    dev_mem[0] = 8'hA5;
    for (int i = 1; i < 4; i++) dev_mem[i] = 8'($urandom_range(0, 255));

    // reset values
    repeat (3) @(negedge clk);
    check("reset_pins",
          32'({cs_n, rd_n, wr_n, ppi_reset, d_oe, bus.req_ready, bus.rsp_valid,
               ppi_a, d_out, bus.rsp_rdata}),
          32'({1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00}));
    check("reset_state", 32'(dbg_state), 32'(ST_INIT));
    release_reset("rst1");

    // mode-set control word
    cw = 8'h00;
    cw[CW_MODE_SET_BIT] = 1'b1;
    req_q.push_back({1'b1, PPI_A_CW, cw});
    run_reqs(1'b0);
    drain();

    // read port A
    req_q.push_back({1'b0, PPI_A_PA, 8'h00});
    run_reqs(1'b0);
    drain();

    // back-to-back mix with req_valid held high
    gap_valid = 1'b0;
    b2b_mode  = 1'b1;
    for (int i = 0; i < 6; i++)
      req_q.push_back({1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       8'($urandom_range(0, 255))});
    run_reqs(1'b1);
    drain();
    b2b_mode = 1'b0;

    // reset during the second strobe cycle of a write
    req_q.push_back({1'b1, PPI_A_PB, 8'h5A});
    run_reqs(1'b0);
    n = 0;
    while (n < 2 && cyc < 5000) begin
      @(negedge clk);
      if (!wr_n) n++;
    end
    check("reached_strobe2", n, 2);
    RESET = 1'b1;
    @(negedge clk);
    check("abort_wr_n", 32'(wr_n), 32'd1);
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_d_oe", 32'(d_oe), 32'd0);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_ppi_reset", 32'(ppi_reset), 32'd1);
    exp_q.delete();
    acc_q.delete();
    last_rd = 8'h00;
    repeat (2) @(negedge clk);
    check("abort_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    release_reset("rst2");

    // normal traffic after the re-init
    req_q.push_back({1'b1, PPI_A_PC, 8'($urandom_range(0, 255))});
    req_q.push_back({1'b0, PPI_A_PB, 8'h00});
    run_reqs(1'b0);
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
